uart_byte_rx: RTL and testbench



---
 rtl/uart_pkg.sv | 36 +++
 rtl/uart_baud_tick.sv | 54 +++++
 rtl/uart_byte_rx.sv | 128 ++++++++++++
 tb/tb_uart_byte_rx.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: rate table, oversampling constants and receiver FSM encoding shared by
// the UART receive and transmit blocks.
package uart_pkg;

  localparam int         OVERSAMPLE = 16;
  localparam logic [3:0] TICK_LAST  = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] SAMPLE_LO  = 4'd6;
  localparam logic [3:0] SAMPLE_HI  = 4'd11;
  localparam logic [2:0] MAJ_THRESH = 3'd4;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  function automatic int baud_rate(input logic [2:0] sel);
    int rate;
    case (sel)
      3'd1:    rate = 19200;
      3'd2:    rate = 38400;
      3'd3:    rate = 57600;
      3'd4:    rate = 115200;
      3'd5:    rate = 230400;
      default: rate = 9600;
    endcase
    return rate;
  endfunction

  // Rounded to nearest so 50 MHz gives 325, 162, 80, 53, 26, 13.
  function automatic logic [15:0] baud_div(input logic [2:0] sel, input int clk_freq);
    int rate;
    rate = baud_rate(sel);
    return 16'((clk_freq + rate * 8) / (rate * 16) - 1);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: 16x oversampling tick divider. The rate is latched and the phase
// restarted for as long as i_clr is high.
module uart_baud_tick import uart_pkg::*; #(
  parameter int CLK_FREQ = 50_000_000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [2:0] i_baud_set,
  input  logic       i_clr,
  output logic       o_tick,
  output logic [3:0] o_tick_idx
);

  logic [15:0] w_div_sel;
  logic [15:0] r_div;
  logic [15:0] r_cnt;
  logic [3:0]  r_idx;
  logic        w_wrap;

  // Each entry folds to a constant, so no runtime divider is built.
  always_comb begin
    case (i_baud_set)
      3'd1:    w_div_sel = baud_div(3'd1, CLK_FREQ);
      3'd2:    w_div_sel = baud_div(3'd2, CLK_FREQ);
      3'd3:    w_div_sel = baud_div(3'd3, CLK_FREQ);
      3'd4:    w_div_sel = baud_div(3'd4, CLK_FREQ);
      3'd5:    w_div_sel = baud_div(3'd5, CLK_FREQ);
      default: w_div_sel = baud_div(3'd0, CLK_FREQ);
    endcase
  end

  assign w_wrap = (r_cnt == r_div);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_div <= baud_div(3'd0, CLK_FREQ);
      r_cnt <= '0;
      r_idx <= '0;
    end else if (i_clr) begin
      r_div <= w_div_sel;
      r_cnt <= '0;
      r_idx <= '0;
    end else if (w_wrap) begin
      r_cnt <= '0;
      r_idx <= r_idx + 4'd1;
    end else begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  assign o_tick     = w_wrap & ~i_clr;
  assign o_tick_idx = r_idx;

endmodule

// File: rtl/uart_byte_rx.sv
// uart_byte_rx: 8N1 receiver, 16x oversampled, 6-sample majority per bit.
// Defining UART_RX_FRAME_ERR_EN adds frame_err (stop-bit majority low).
// state | meaning
// IDLE  | waiting for a 1->0 edge on the synchronized line
// START | validating the start bit
// DATA  | shifting 8 data bits, LSB first
// STOP  | voting the stop bit, then done
module uart_byte_rx import uart_pkg::*; #(
  parameter int CLK_FREQ = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] baud_set,
  input  logic       rs232_rx,
  output logic [7:0] data_byte,
  output logic       rx_done,
  output logic       uart_state
`ifdef UART_RX_FRAME_ERR_EN
  ,
  output logic       frame_err
`endif
);

  logic [2:0] r_sync;
  logic [2:0] r_vld;
  logic [1:0] r_state;
  logic [2:0] r_ones;
  logic [2:0] r_bit_cnt;
  logic [7:0] r_shift;
  logic [7:0] r_data;
  logic       r_done;
  logic       r_ferr;
  logic       w_line;
  logic       w_fall;
  logic       w_tick;
  logic [3:0] w_idx;
  logic [2:0] w_ones_next;
  logic       w_bit;
  logic       w_in_window;

  // r_vld keeps reset values of the synchronizer from looking like a falling edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= 3'b111;
      r_vld  <= 3'b000;
    end else begin
      r_sync <= {r_sync[1:0], rs232_rx};
      r_vld  <= {r_vld[1:0], 1'b1};
    end
  end

  assign w_line = r_sync[1];
  assign w_fall = r_vld[2] & r_sync[2] & ~r_sync[1];

  uart_baud_tick #(.CLK_FREQ(CLK_FREQ)) u_tick (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_baud_set (baud_set),
    .i_clr      (r_state == S_IDLE),
    .o_tick     (w_tick),
    .o_tick_idx (w_idx)
  );

  assign w_in_window = (w_idx >= SAMPLE_LO) && (w_idx <= SAMPLE_HI);
  assign w_ones_next = r_ones + {2'b00, w_line};
  assign w_bit       = (w_ones_next >= MAJ_THRESH);

  always_ff @(posedge clk) begin
    if (rst || r_state == S_IDLE) begin
      r_ones <= '0;
    end else if (w_tick) begin
      if (w_idx == TICK_LAST)
        r_ones <= '0;
      else if (w_in_window)
        r_ones <= w_ones_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_data    <= '0;
      r_done    <= 1'b0;
      r_ferr    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_ferr <= 1'b0;
      case (r_state)
        S_IDLE: if (w_fall) r_state <= S_START;
        S_START: if (w_tick) begin
          if (w_idx == SAMPLE_HI && w_bit) begin
            r_state <= S_IDLE;
          end else if (w_idx == TICK_LAST) begin
            r_state   <= S_DATA;
            r_bit_cnt <= '0;
          end
        end
        S_DATA: if (w_tick) begin
          if (w_idx == SAMPLE_HI) r_shift <= {w_bit, r_shift[7:1]};
          if (w_idx == TICK_LAST) begin
            if (r_bit_cnt == 3'd7) r_state <= S_STOP;
            r_bit_cnt <= r_bit_cnt + 3'd1;
          end
        end
        S_STOP: if (w_tick && w_idx == SAMPLE_HI) begin
          // Finish at the stop-bit centre so a following start edge is not missed.
          r_done  <= 1'b1;
          r_data  <= r_shift;
          r_state <= S_IDLE;
`ifdef UART_RX_FRAME_ERR_EN
          r_ferr  <= ~w_bit;
`endif
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign data_byte  = r_data;
  assign rx_done    = r_done;
  assign uart_state = (r_state != S_IDLE);
`ifdef UART_RX_FRAME_ERR_EN
  assign frame_err  = r_ferr;
`endif

endmodule

// File: tb/tb_uart_byte_rx.sv
// tb_uart_byte_rx: directed bench driving 8N1 frames onto rs232_rx and checking
// received bytes, strobe timing, false-start rejection and reset behaviour.
module tb_uart_byte_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] baud_set = 3'd0;
  logic       rs232_rx = 1'b1;
  logic [7:0] data_byte;
  logic       rx_done;
  logic       uart_state;
`ifdef UART_RX_FRAME_ERR_EN
  logic       frame_err;
`endif

  uart_byte_rx #(.CLK_FREQ(50_000_000)) dut (
    .clk        (clk),
    .rst        (rst),
    .baud_set   (baud_set),
    .rs232_rx   (rs232_rx),
    .data_byte  (data_byte),
    .rx_done    (rx_done),
    .uart_state (uart_state)
`ifdef UART_RX_FRAME_ERR_EN
    ,
    .frame_err  (frame_err)
`endif
  );

  always #10 clk = ~clk;

  localparam int PER0 = 16 * 326;  // 9600 baud bit period in clk
  localparam int PER4 = 16 * 27;   // 115200 baud bit period in clk

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int t_fall   = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int done_wide = 0;
  int rise_cyc = 0;
  int fall_cyc = 0;
  logic done_state = 1'b0;
  logic done_ferr  = 1'b0;
  logic prev_state = 1'b0;
  logic prev_done  = 1'b0;
  logic [7:0] got[$];
  int base;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_done) begin
      if (prev_done) done_wide++;
      done_cnt++;
      done_cyc   = cyc;
      done_state = uart_state;
      got.push_back(data_byte);
`ifdef UART_RX_FRAME_ERR_EN
      done_ferr  = frame_err;
`endif
    end
    if (uart_state && !prev_state) rise_cyc = cyc;
    if (!uart_state && prev_state) fall_cyc = cyc;
    prev_state = uart_state;
    prev_done  = rx_done;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_near(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs >= exp - 2 && obs <= exp + 2) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d +-2", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input logic v, input int clks);
    rs232_rx = v;
    repeat (clks) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input int per, input logic stop_v,
                            input int glitch_bit);
    int t;
    t = per / 16;
    t_fall = cyc;
    drive_bit(1'b0, per);
    for (int i = 0; i < 8; i++) begin
      if (i == glitch_bit) begin
        drive_bit(d[i], 8 * t);
        drive_bit(~d[i], t);
        drive_bit(d[i], 7 * t);
      end else begin
        drive_bit(d[i], per);
      end
    end
    drive_bit(stop_v, per);
  endtask

  initial begin
    logic [7:0] partial;
    partial = 8'h2A;

    repeat (4) @(posedge clk);
    #1;
    check("reset data_byte", {24'd0, data_byte}, 32'h00);
    check("reset rx_done", {31'd0, rx_done}, 32'd0);
    check("reset uart_state", {31'd0, uart_state}, 32'd0);
`ifdef UART_RX_FRAME_ERR_EN
    check("reset frame_err", {31'd0, frame_err}, 32'd0);
`endif
    rst = 1'b0;
    drive_bit(1'b1, 20);

    // 9600 baud, single byte
    baud_set = 3'd0;
    base = done_cnt;
    send_frame(8'd24, PER0, 1'b1, -1);
    drive_bit(1'b1, 50);
    check("b9600 done count", done_cnt - base, 1);
    check("b9600 data", {24'd0, got[got.size()-1]}, 32'h18);
    check("b9600 detect latency", rise_cyc - t_fall, 3);
    check_near("b9600 done latency", done_cyc - rise_cyc, 156 * 326);
    check("b9600 state drop with done", fall_cyc, done_cyc);
    check("b9600 state at done", {31'd0, done_state}, 32'd0);
`ifdef UART_RX_FRAME_ERR_EN
    check("b9600 frame_err", {31'd0, done_ferr}, 32'd0);
`endif

    // 115200 baud, back-to-back frames
    baud_set = 3'd4;
    base = done_cnt;
    send_frame(8'h55, PER4, 1'b1, -1);
    send_frame(8'hAA, PER4, 1'b1, -1);
    drive_bit(1'b1, 50);
    check("b2b done count", done_cnt - base, 2);
    check("b2b first byte", {24'd0, got[got.size()-2]}, 32'h55);
    check("b2b second byte", {24'd0, got[got.size()-1]}, 32'hAA);
    check_near("b2b done latency", done_cyc - rise_cyc, 156 * 27);

    // false start at 9600
    baud_set = 3'd0;
    base = done_cnt;
    t_fall = cyc;
    drive_bit(1'b0, 100);
    drive_bit(1'b1, 4100);
    check("false start done count", done_cnt - base, 0);
    check("false start detect", rise_cyc - t_fall, 3);
    check_near("false start release", fall_cyc - rise_cyc, 12 * 326);

    // glitch on tick 8 of bit 5
    baud_set = 3'd4;
    base = done_cnt;
    send_frame(8'hF0, PER4, 1'b1, 5);
    drive_bit(1'b1, 50);
    check("glitch done count", done_cnt - base, 1);
    check("glitch data", {24'd0, got[got.size()-1]}, 32'hF0);

    // stop bit held low
    base = done_cnt;
    send_frame(8'h3C, PER4, 1'b0, -1);
    drive_bit(1'b1, 100);
    check("bad stop done count", done_cnt - base, 1);
    check("bad stop data", {24'd0, got[got.size()-1]}, 32'h3C);
`ifdef UART_RX_FRAME_ERR_EN
    check("bad stop frame_err", {31'd0, done_ferr}, 32'd1);
`endif
    check("done width", done_wide, 0);

    // reset during bit 4 (a 0 bit), line still low at release
    base = done_cnt;
    drive_bit(1'b0, PER4);
    for (int i = 0; i < 4; i++) drive_bit(partial[i], PER4);
    drive_bit(partial[4], PER4 / 2);
    check("pre-reset busy", {31'd0, uart_state}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid reset data_byte", {24'd0, data_byte}, 32'h00);
    check("mid reset rx_done", {31'd0, rx_done}, 32'd0);
    check("mid reset uart_state", {31'd0, uart_state}, 32'd0);
    rst = 1'b0;
    drive_bit(1'b0, 200);
    check("low after reset no start", {31'd0, uart_state}, 32'd0);
    drive_bit(1'b1, 100);
    send_frame(8'hA5, PER4, 1'b1, -1);
    drive_bit(1'b1, 50);
    check("post reset done count", done_cnt - base, 1);
    check("post reset data", {24'd0, got[got.size()-1]}, 32'hA5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
